// File: rtl/txfifo_sync_pkt.sv
// Single-clock, packet-aware TX data FIFO.
// Words are tagged with an EOP bit and become readable only once their packet
// is committed. A partial packet can be rewound with wrabort. A packet that
// overflows the buffer is dropped as a whole when its EOP arrives.
module txfifo_sync_pkt #(
  parameter int WIDTH     = 64,
  parameter int PTR       = 10,
  parameter int AFULL_TH  = 1000,
  parameter bit SHOWAHEAD = 1'b0
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             wrreq,
  input  logic [WIDTH-1:0] data,
  input  logic             wreop,
  input  logic             wrabort,
  output logic             wrfull,
  output logic             wrafull,
  output logic [PTR:0]     wrusedw,
  input  logic             rdreq,
  output logic [WIDTH-1:0] q,
  output logic             rdeop,
  output logic             rdempty,
  output logic [PTR:0]     rdusedw,
  output logic [PTR:0]     pkt_cnt,
  input  logic             err_clr,
  output logic             ovf,
  output logic             udf
);

  localparam int           DEPTH   = 2 ** PTR;
  localparam logic [PTR:0] DEPTH_W = (PTR + 1)'(DEPTH);
  localparam logic [PTR:0] AFULL_W = (PTR + 1)'(AFULL_TH);

  logic [WIDTH:0]   mem [DEPTH];
  logic [PTR:0]     wr_ptr;
  logic [PTR:0]     cm_ptr;
  logic [PTR:0]     rd_ptr;
  logic [PTR:0]     pkt_cnt_r;
  logic             bad;
  logic             ovf_r;
  logic             udf_r;
  logic [WIDTH-1:0] q_r;
  logic             rdeop_r;
  logic [WIDTH:0]   head;
  logic             wr_accept;
  logic             wr_commit;
  logic             ovf_set;
  logic             udf_set;
  logic             rd_accept;
  logic             rd_eop;

  // Occupancy is decoded purely from the registered pointers; the wrap bit
  // makes full and empty distinguishable.
  assign wrusedw = wr_ptr - rd_ptr;
  assign rdusedw = cm_ptr - rd_ptr;
  assign wrfull  = (wrusedw == DEPTH_W);
  assign wrafull = (wrusedw >= AFULL_W);
  assign rdempty = (rdusedw == '0);
  assign pkt_cnt = pkt_cnt_r;
  assign ovf     = ovf_r;
  assign udf     = udf_r;

  assign head      = mem[rd_ptr[PTR-1:0]];
  assign wr_accept = wrreq & ~wrfull & ~wrabort & ~bad;
  assign wr_commit = wr_accept & wreop;
  assign ovf_set   = wrreq & wrfull & ~wrabort;
  assign rd_accept = rdreq & ~rdempty;
  assign udf_set   = rdreq & rdempty;
  assign rd_eop    = rd_accept & head[WIDTH];

  // Show-ahead presents the head entry directly; it is masked while nothing
  // is committed so the bus never shows uncommitted or stale data.
  assign q     = SHOWAHEAD ? (rdempty ? '0 : head[WIDTH-1:0]) : q_r;
  assign rdeop = SHOWAHEAD ? (~rdempty & head[WIDTH]) : rdeop_r;

  // Storage array: EOP bit kept alongside each data word.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[PTR-1:0]] <= {wreop, data};
    end
  end

  // Write side: accept, commit, abort rewind and overflow drop handling.
  always_ff @(posedge clk) begin
    if (aclr) begin
      wr_ptr <= '0;
      cm_ptr <= '0;
      bad    <= 1'b0;
    end else if (wrabort) begin
      wr_ptr <= cm_ptr;
      bad    <= 1'b0;
    end else if (wrreq) begin
      if (bad || wrfull) begin
        if (wreop) begin
          wr_ptr <= cm_ptr;
          bad    <= 1'b0;
        end else begin
          bad    <= 1'b1;
        end
      end else begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wreop) begin
          cm_ptr <= wr_ptr + 1'b1;
        end
      end
    end
  end

  // Read side: advance the read pointer and capture the registered output word.
  always_ff @(posedge clk) begin
    if (aclr) begin
      rd_ptr  <= '0;
      q_r     <= '0;
      rdeop_r <= 1'b0;
    end else if (rd_accept) begin
      rd_ptr  <= rd_ptr + 1'b1;
      q_r     <= head[WIDTH-1:0];
      rdeop_r <= head[WIDTH];
    end
  end

  // Packet count: commits add, EOP reads subtract, both together cancel.
  always_ff @(posedge clk) begin
    if (aclr) begin
      pkt_cnt_r <= '0;
    end else begin
      pkt_cnt_r <= pkt_cnt_r + (PTR + 1)'(wr_commit) - (PTR + 1)'(rd_eop);
    end
  end

  // Sticky error flags; a new error event takes priority over err_clr.
  always_ff @(posedge clk) begin
    if (aclr) begin
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_r <= 1'b1;
      end else if (err_clr) begin
        ovf_r <= 1'b0;
      end
      if (udf_set) begin
        udf_r <= 1'b1;
      end else if (err_clr) begin
        udf_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_txfifo_sync_pkt.sv
// Self-checking bench for txfifo_sync_pkt with a 16-entry buffer.
// Two instances share every input: one registered-read, one show-ahead.
module tb_txfifo_sync_pkt;

  localparam int W  = 16;
  localparam int P  = 4;
  localparam int TH = 12;

  logic         clk = 1'b0;
  logic         aclr = 1'b0;
  logic         wrreq = 1'b0;
  logic [W-1:0] data = '0;
  logic         wreop = 1'b0;
  logic         wrabort = 1'b0;
  logic         rdreq = 1'b0;
  logic         err_clr = 1'b0;

  logic         wrfull0, wrafull0, rdeop0, rdempty0, ovf0, udf0;
  logic [P:0]   wrusedw0, rdusedw0, pkt_cnt0;
  logic [W-1:0] q0;
  logic         wrfull1, wrafull1, rdeop1, rdempty1, ovf1, udf1;
  logic [P:0]   wrusedw1, rdusedw1, pkt_cnt1;
  logic [W-1:0] q1;

  int checks = 0;
  int errors = 0;

  // Expected read stream: {eop, data}, pushed when a surviving packet is driven.
  logic [W:0] exp_q[$];

  typedef struct {
    logic         wrreq;
    logic [W-1:0] data;
    logic         wreop;
    logic         rdreq;
    logic         exp_rdempty;
    logic [P:0]   exp_wrusedw;
    logic [P:0]   exp_rdusedw;
    logic [P:0]   exp_pkt_cnt;
    logic [W-1:0] exp_q0;
    logic         exp_eop0;
    logic [W-1:0] exp_q1;
    logic         exp_eop1;
  } vec_t;

  vec_t vecs[8];

  txfifo_sync_pkt #(.WIDTH(W), .PTR(P), .AFULL_TH(TH), .SHOWAHEAD(1'b0)) dut0 (
    .clk(clk), .aclr(aclr), .wrreq(wrreq), .data(data), .wreop(wreop), .wrabort(wrabort),
    .wrfull(wrfull0), .wrafull(wrafull0), .wrusedw(wrusedw0), .rdreq(rdreq), .q(q0),
    .rdeop(rdeop0), .rdempty(rdempty0), .rdusedw(rdusedw0), .pkt_cnt(pkt_cnt0),
    .err_clr(err_clr), .ovf(ovf0), .udf(udf0)
  );

  txfifo_sync_pkt #(.WIDTH(W), .PTR(P), .AFULL_TH(TH), .SHOWAHEAD(1'b1)) dut1 (
    .clk(clk), .aclr(aclr), .wrreq(wrreq), .data(data), .wreop(wreop), .wrabort(wrabort),
    .wrfull(wrfull1), .wrafull(wrafull1), .wrusedw(wrusedw1), .rdreq(rdreq), .q(q1),
    .rdeop(rdeop1), .rdempty(rdempty1), .rdusedw(rdusedw1), .pkt_cnt(pkt_cnt1),
    .err_clr(err_clr), .ovf(ovf1), .udf(udf1)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, then release them.
  task automatic applyStimulus(input logic wr, input logic [W-1:0] d, input logic eop,
                               input logic ab, input logic rd, input logic clr);
    wrreq = wr; data = d; wreop = eop; wrabort = ab; rdreq = rd; err_clr = clr;
    @(posedge clk);
    #1;
    wrreq = 1'b0; data = '0; wreop = 1'b0; wrabort = 1'b0; rdreq = 1'b0; err_clr = 1'b0;
  endtask

  task automatic doReset();
    aclr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    aclr = 1'b0;
    exp_q.delete();
  endtask

  // Write a word; when it belongs to a packet that must survive, queue it.
  task automatic writeWord(input logic [W-1:0] d, input logic eop, input logic keep);
    if (keep) exp_q.push_back({eop, d});
    applyStimulus(1'b1, d, eop, 1'b0, 1'b0, 1'b0);
  endtask

  // Pop one expected word: show-ahead head before the edge, registered q after.
  task automatic readCheck(input string name);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      checkOutput({name, "_queue_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    checkOutput({name, "_sa1_q"}, 32'(q1), 32'(e[W-1:0]));
    checkOutput({name, "_sa1_eop"}, 32'(rdeop1), 32'(e[W]));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput({name, "_sa0_q"}, 32'(q0), 32'(e[W-1:0]));
    checkOutput({name, "_sa0_eop"}, 32'(rdeop0), 32'(e[W]));
  endtask

  initial begin
    logic [W:0] e;

    vecs[0] = '{1'b1, 16'h1, 1'b0, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 16'h0, 1'b0, 16'h0, 1'b0};
    vecs[1] = '{1'b1, 16'h2, 1'b0, 1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 16'h0, 1'b0, 16'h0, 1'b0};
    vecs[2] = '{1'b1, 16'h3, 1'b0, 1'b0, 1'b1, 5'd3, 5'd0, 5'd0, 16'h0, 1'b0, 16'h0, 1'b0};
    vecs[3] = '{1'b1, 16'h4, 1'b1, 1'b0, 1'b0, 5'd4, 5'd4, 5'd1, 16'h0, 1'b0, 16'h1, 1'b0};
    vecs[4] = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 5'd3, 5'd3, 5'd1, 16'h1, 1'b0, 16'h2, 1'b0};
    vecs[5] = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 5'd2, 5'd2, 5'd1, 16'h2, 1'b0, 16'h3, 1'b0};
    vecs[6] = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd1, 5'd1, 16'h3, 1'b0, 16'h4, 1'b1};
    vecs[7] = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 16'h4, 1'b1, 16'h0, 1'b0};

    // Reset state
    doReset();
    checkOutput("rst_rdempty", 32'(rdempty0), 32'd1);
    checkOutput("rst_wrfull", 32'(wrfull0), 32'd0);
    checkOutput("rst_wrafull", 32'(wrafull0), 32'd0);
    checkOutput("rst_wrusedw", 32'(wrusedw0), 32'd0);
    checkOutput("rst_rdusedw", 32'(rdusedw0), 32'd0);
    checkOutput("rst_pkt_cnt", 32'(pkt_cnt0), 32'd0);
    checkOutput("rst_ovf", 32'(ovf0), 32'd0);
    checkOutput("rst_udf", 32'(udf0), 32'd0);
    checkOutput("rst_q0", 32'(q0), 32'd0);
    checkOutput("rst_q1", 32'(q1), 32'd0);
    checkOutput("rst_rdempty1", 32'(rdempty1), 32'd1);

    // Commit visibility, table driven
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].wrreq, vecs[i].data, vecs[i].wreop, 1'b0, vecs[i].rdreq, 1'b0);
      checkOutput($sformatf("vec%0d_rdempty", i), 32'(rdempty0), 32'(vecs[i].exp_rdempty));
      checkOutput($sformatf("vec%0d_wrusedw", i), 32'(wrusedw0), 32'(vecs[i].exp_wrusedw));
      checkOutput($sformatf("vec%0d_rdusedw", i), 32'(rdusedw0), 32'(vecs[i].exp_rdusedw));
      checkOutput($sformatf("vec%0d_pkt_cnt", i), 32'(pkt_cnt0), 32'(vecs[i].exp_pkt_cnt));
      checkOutput($sformatf("vec%0d_q0", i), 32'(q0), 32'(vecs[i].exp_q0));
      checkOutput($sformatf("vec%0d_eop0", i), 32'(rdeop0), 32'(vecs[i].exp_eop0));
      checkOutput($sformatf("vec%0d_q1", i), 32'(q1), 32'(vecs[i].exp_q1));
      checkOutput($sformatf("vec%0d_eop1", i), 32'(rdeop1), 32'(vecs[i].exp_eop1));
    end

    // Abort of a partial packet
    doReset();
    for (int i = 0; i < 5; i++) writeWord(16'(16'h20 + i), 1'b0, 1'b0);
    checkOutput("abort_pre_wrusedw", 32'(wrusedw0), 32'd5);
    checkOutput("abort_pre_rdempty", 32'(rdempty0), 32'd1);
    applyStimulus(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("abort_wrusedw", 32'(wrusedw0), 32'd0);
    checkOutput("abort_rdempty", 32'(rdempty0), 32'd1);
    checkOutput("abort_pkt_cnt", 32'(pkt_cnt0), 32'd0);
    writeWord(16'hA1, 1'b0, 1'b1);
    writeWord(16'hA2, 1'b1, 1'b1);
    checkOutput("abort_next_rdusedw", 32'(rdusedw0), 32'd2);
    readCheck("abort_rd0");
    readCheck("abort_rd1");
    checkOutput("abort_end_pkt_cnt", 32'(pkt_cnt0), 32'd0);

    // Overflow drop of an oversize packet, plus almost-full threshold
    doReset();
    writeWord(16'hB0, 1'b0, 1'b1);
    writeWord(16'hB1, 1'b0, 1'b1);
    writeWord(16'hB2, 1'b1, 1'b1);
    checkOutput("ovf_a_wrusedw", 32'(wrusedw0), 32'd3);
    for (int k = 1; k <= 20; k++) begin
      writeWord(16'(16'hC00 + k), (k == 20), 1'b0);
      if (k == 8)  checkOutput("afull_at_11", 32'(wrafull0), 32'd0);
      if (k == 9)  checkOutput("afull_at_12", 32'(wrafull0), 32'd1);
      if (k == 12) checkOutput("wrfull_at_15", 32'(wrfull0), 32'd0);
      if (k == 13) begin
        checkOutput("wrfull_at_16", 32'(wrfull0), 32'd1);
        checkOutput("ovf_not_yet", 32'(ovf0), 32'd0);
      end
      if (k == 14) checkOutput("ovf_set", 32'(ovf0), 32'd1);
      if (k == 19) checkOutput("ovf_wrusedw_held", 32'(wrusedw0), 32'd16);
    end
    checkOutput("ovf_drop_wrusedw", 32'(wrusedw0), 32'd3);
    checkOutput("ovf_drop_wrfull", 32'(wrfull0), 32'd0);
    checkOutput("ovf_drop_pkt_cnt", 32'(pkt_cnt0), 32'd1);
    checkOutput("ovf_drop_rdusedw", 32'(rdusedw0), 32'd3);
    readCheck("ovf_rd0");
    readCheck("ovf_rd1");
    checkOutput("ovf_mid_pkt_cnt", 32'(pkt_cnt0), 32'd1);
    readCheck("ovf_rd2");
    checkOutput("ovf_end_pkt_cnt", 32'(pkt_cnt0), 32'd0);
    checkOutput("ovf_end_rdempty", 32'(rdempty0), 32'd1);
    writeWord(16'h77, 1'b1, 1'b1);
    readCheck("ovf_after_drop");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_cleared", 32'(ovf0), 32'd0);

    // Wrap and concurrency: single-word packets with rdreq held high
    doReset();
    for (int i = 0; i <= 100; i++) begin
      e = '0;
      if (i >= 1) begin
        e = exp_q.pop_front();
        checkOutput($sformatf("wrap%0d_sa1_q", i), 32'(q1), 32'(e[W-1:0]));
      end
      if (i < 100) exp_q.push_back({1'b1, 16'(16'h100 + i)});
      applyStimulus(i < 100, 16'(16'h100 + i), 1'b1, 1'b0, 1'b1, 1'b0);
      if (i >= 1) begin
        checkOutput($sformatf("wrap%0d_sa0_q", i), 32'(q0), 32'(e[W-1:0]));
        checkOutput($sformatf("wrap%0d_sa0_eop", i), 32'(rdeop0), 32'd1);
      end
      if (i < 100) begin
        checkOutput($sformatf("wrap%0d_pkt_cnt", i), 32'(pkt_cnt0), 32'd1);
        checkOutput($sformatf("wrap%0d_wrusedw", i), 32'(wrusedw1), 32'd1);
      end
    end
    checkOutput("wrap_end_rdempty", 32'(rdempty0), 32'd1);
    checkOutput("wrap_end_pkt_cnt", 32'(pkt_cnt1), 32'd0);
    checkOutput("wrap_udf_first", 32'(udf0), 32'd1);

    // Underflow and error flag clearing
    doReset();
    writeWord(16'h55, 1'b1, 1'b1);
    readCheck("udf_rd");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("udf_set0", 32'(udf0), 32'd1);
    checkOutput("udf_set1", 32'(udf1), 32'd1);
    checkOutput("udf_q_hold", 32'(q0), 32'h55);
    checkOutput("udf_rdusedw", 32'(rdusedw0), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("udf_clr", 32'(udf0), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("udf_set_wins", 32'(udf0), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("udf_clr2", 32'(udf0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
